// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states, Booth op codes
// and the iteration count.
package booth_multiplier_pkg;

  localparam int unsigned MUL_ITER = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_t;

  // {Q[0], q_1}: 01 -> add M, 10 -> subtract M, 00/11 -> no-op
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    booth_op_t op;
    case ({q0, qm1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_multiplier_adder.sv
// 8-bit adder/subtractor: b is inverted when cin = 1, so sum = a - b in that case.
module Parallel_Adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] b_x;

  always_comb begin
    b_x         = b ^ {8{cin}};
    {cout, sum} = {1'b0, a} + {1'b0, b_x} + {8'd0, cin};
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential 8x8 signed radix-2 Booth multiplier; one shift-add iteration per
// clock through Parallel_Adder, start/busy/done handshake, 16-bit product.
module booth_multiplier
  import booth_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam logic [2:0] CNT_LAST = 3'(MUL_ITER - 1);

  state_t     state;
  logic [7:0] m_q;
  logic [7:0] q_q;
  logic [7:0] a_q;
  logic       q_1;
  logic [2:0] cnt;

  booth_op_t  op;
  logic       sub;
  logic [7:0] sum;
  logic       cout;
  logic [7:0] r;
  logic       s8;
  logic [7:0] a_next;
  logic [7:0] q_next;
  logic       q_1_next;

  Parallel_Adder u_add (
    .a    (a_q),
    .b    (m_q),
    .cin  (sub),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    op  = booth_decode(q_q[0], q_1);
    sub = (op == OP_SUB);
    if (op == OP_NOP) begin
      r  = a_q;
      s8 = a_q[7];
    end else begin
      r  = sum;
      // true sign of the 9-bit A +/- M, needed when the 8-bit result overflows
      s8 = a_q[7] ^ (m_q[7] ^ sub) ^ cout;
    end
    {a_next, q_next, q_1_next} = {s8, r, q_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_q   <= mcand;
            q_q   <= mplier;
            a_q   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= ST_CALC;
            busy  <= 1'b1;
          end
        end
        ST_CALC: begin
          a_q <= a_next;
          q_q <= q_next;
          q_1 <= q_1_next;
          cnt <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            product <= {a_next, q_next};
            done    <= 1'b1;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
